// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Self-timed instruction fetch for the TinyMIPS multicycle datapath.
//   Issues BEATS = INSTR_W/DATA_W consecutive narrow reads starting at pc,
//   packs each beat into its lane of instr (little or big endian), then
//   pulses instr_valid for one cycle and advances pc by BEATS.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               request one instruction fetch (held if stalled)
//   stall               freeze an in-progress fetch
//   flush               abort a fetch, pc unchanged
//   pc_load, pc_in      load pc (also aborts a fetch)
//   memdata, mem_valid  memory read data and its valid
//   mem_req, adr        memory read request and address
//   instr, instr_valid  assembled instruction and its one-cycle strobe
//   pc                  program counter
//   busy                high while fetching

// One DATA_W-wide lane of the instruction register.
module fetch_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

module fetch_sequencer #(
    parameter int DATA_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               flush,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  memdata,
    input  logic               mem_valid,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  adr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
);
    localparam int BEATS = INSTR_W / DATA_W;
    localparam int BW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    generate
        if ((INSTR_W % DATA_W) != 0 || (INSTR_W / DATA_W) < 2) begin : g_bad_params
            $error("fetch_sequencer: INSTR_W must be a multiple of DATA_W with at least 2 beats");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic            accept;
    logic [BEATS-1:0]             lane_we;
    logic [BEATS-1:0][DATA_W-1:0] lanes;

    // A beat lands only when nothing of higher priority claims this edge.
    assign accept  = (state == FETCH) && mem_valid && !stall && !pc_load && !flush;
    assign mem_req = (state == FETCH) && !stall;
    assign adr     = pc + ADDR_W'(beat);
    assign instr   = lanes;

    generate
        for (genvar i = 0; i < BEATS; i++) begin : g_lane
            // Beat index that fills lane i.
            localparam int LB = (BIG_ENDIAN != 0) ? (BEATS - 1 - i) : i;
            assign lane_we[i] = accept && (beat == BW'(LB));
            fetch_lane #(.W(DATA_W)) u_lane (
                .clk   (clk),
                .reset (reset),
                .we    (lane_we[i]),
                .d     (memdata),
                .q     (lanes[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat        <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (pc_load || flush) begin
                if (pc_load) pc <= pc_in;
                state <= IDLE;
                beat  <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stall) begin
                            state <= FETCH;
                            beat  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (mem_valid && !stall) begin
                            if (beat == LAST) begin
                                state       <= DONE;
                                beat        <= '0;
                                pc          <= pc + ADDR_W'(BEATS);
                                instr_valid <= 1'b1;
                                busy        <= 1'b0;
                            end else begin
                                beat <= beat + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (start && !stall) begin
                            state <= FETCH;
                            beat  <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        beat  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic clk, reset, start, stall, flush, pc_load, mem_valid;
    logic [7:0] pc_in;

    logic [7:0]  a_memdata, a_adr, a_pc;
    logic        a_mem_req, a_instr_valid, a_busy;
    logic [31:0] a_instr;

    logic [15:0] b_memdata;
    logic [7:0]  b_adr, b_pc;
    logic        b_mem_req, b_instr_valid, b_busy;
    logic [31:0] b_instr;

    logic [7:0]  mema [0:255];
    logic [15:0] memb [0:255];

    int passed = 0;
    int total  = 0;

    assign a_memdata = mema[a_adr];
    assign b_memdata = memb[b_adr];

    fetch_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .pc_load(pc_load), .pc_in(pc_in), .memdata(a_memdata), .mem_valid(mem_valid),
        .mem_req(a_mem_req), .adr(a_adr), .instr(a_instr), .instr_valid(a_instr_valid),
        .pc(a_pc), .busy(a_busy)
    );

    fetch_sequencer #(.DATA_W(16), .INSTR_W(32), .ADDR_W(8), .BIG_ENDIAN(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .pc_load(pc_load), .pc_in(pc_in), .memdata(b_memdata), .mem_valid(mem_valid),
        .mem_req(b_mem_req), .adr(b_adr), .instr(b_instr), .instr_valid(b_instr_valid),
        .pc(b_pc), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; start = 0; stall = 0; flush = 0; pc_load = 0; mem_valid = 0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1; stall = 0; flush = 0; pc_load = 0; pc_in = 8'h55; mem_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (a_pc !== 8'h00) $display("FAIL rst_pc actual=%h required=00", a_pc); else passed++;
        total++; if (a_instr !== 32'h0) $display("FAIL rst_instr actual=%h required=0", a_instr); else passed++;
        total++; if (a_instr_valid !== 1'b0) $display("FAIL rst_valid actual=%b required=0", a_instr_valid); else passed++;
        total++; if (a_busy !== 1'b0) $display("FAIL rst_busy actual=%b required=0", a_busy); else passed++;
        total++; if (a_mem_req !== 1'b0) $display("FAIL rst_memreq actual=%b required=0", a_mem_req); else passed++;
        reset = 1'b0; start = 0; pc_in = 0; mem_valid = 0;
    endtask

    task automatic test_zero_wait();
        @(negedge clk); start = 1; mem_valid = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++; if (a_adr !== 8'(b) || a_mem_req !== 1'b1)
                $display("FAIL zw_adr%0d actual=%h/%b required=%h/1", b, a_adr, a_mem_req, 8'(b)); else passed++;
            total++; if (a_instr_valid !== 1'b0) $display("FAIL zw_early_valid%0d actual=%b required=0", b, a_instr_valid); else passed++;
            @(negedge clk);
        end
        #1;
        total++; if (a_instr_valid !== 1'b1) $display("FAIL zw_valid actual=%b required=1", a_instr_valid); else passed++;
        total++; if (a_instr !== 32'h00430820) $display("FAIL zw_instr actual=%h required=00430820", a_instr); else passed++;
        total++; if (a_pc !== 8'h04) $display("FAIL zw_pc actual=%h required=04", a_pc); else passed++;
        @(negedge clk); #1;
        total++; if (a_instr_valid !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL zw_pulse actual=%b/%b required=0/0", a_instr_valid, a_busy); else passed++;
    endtask

    task automatic test_wait_states();
        do_reset();
        @(negedge clk); start = 1; mem_valid = 0;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                mem_valid = (k == 2);
                #1;
                total++; if (a_adr !== 8'(b) || a_instr_valid !== 1'b0)
                    $display("FAIL ws_adr%0d_%0d actual=%h/%b required=%h/0", b, k, a_adr, a_instr_valid, 8'(b)); else passed++;
                @(negedge clk);
            end
        end
        mem_valid = 0; #1;
        total++; if (a_instr_valid !== 1'b1) $display("FAIL ws_valid actual=%b required=1", a_instr_valid); else passed++;
        total++; if (a_instr !== 32'h00430820) $display("FAIL ws_instr actual=%h required=00430820", a_instr); else passed++;
        total++; if (a_pc !== 8'h04) $display("FAIL ws_pc actual=%h required=04", a_pc); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk); start = 1; mem_valid = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 2; b++) begin
            #1;
            total++; if (a_adr !== 8'(b)) $display("FAIL st_adr%0d actual=%h required=%h", b, a_adr, 8'(b)); else passed++;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            stall = 1; mem_valid = (k != 1);
            #1;
            total++; if (a_mem_req !== 1'b0 || a_adr !== 8'h02 || a_busy !== 1'b1)
                $display("FAIL st_hold%0d actual=%b/%h/%b required=0/02/1", k, a_mem_req, a_adr, a_busy); else passed++;
            @(negedge clk);
        end
        stall = 0; mem_valid = 1;
        for (int b = 2; b < 4; b++) begin
            #1;
            total++; if (a_adr !== 8'(b) || a_mem_req !== 1'b1)
                $display("FAIL st_resume%0d actual=%h/%b required=%h/1", b, a_adr, a_mem_req, 8'(b)); else passed++;
            @(negedge clk);
        end
        #1;
        total++; if (a_instr_valid !== 1'b1 || a_instr !== 32'h00430820)
            $display("FAIL st_instr actual=%b/%h required=1/00430820", a_instr_valid, a_instr); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk); start = 1; mem_valid = 1;
        @(negedge clk); start = 0;
        repeat (2) @(negedge clk);
        flush = 1;
        @(negedge clk); flush = 0; mem_valid = 0;
        #1;
        total++; if (a_busy !== 1'b0 || a_instr_valid !== 1'b0 || a_pc !== 8'h00)
            $display("FAIL fl_abort actual=%b/%b/%h required=0/0/00", a_busy, a_instr_valid, a_pc); else passed++;
        total++; if (a_instr !== 32'h00000820) $display("FAIL fl_lanes actual=%h required=00000820", a_instr); else passed++;
        @(negedge clk); #1;
        total++; if (a_instr_valid !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL fl_idle actual=%b/%b required=0/0", a_instr_valid, a_busy); else passed++;
        start = 1; mem_valid = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++; if (a_adr !== 8'(b)) $display("FAIL fl_refetch%0d actual=%h required=%h", b, a_adr, 8'(b)); else passed++;
            @(negedge clk);
        end
        #1;
        total++; if (a_instr_valid !== 1'b1 || a_instr !== 32'h00430820 || a_pc !== 8'h04)
            $display("FAIL fl_done actual=%b/%h/%h required=1/00430820/04", a_instr_valid, a_instr, a_pc); else passed++;
    endtask

    task automatic test_pc_load();
        logic [7:0] exp_adr [0:3];
        exp_adr[0] = 8'hFE; exp_adr[1] = 8'hFF; exp_adr[2] = 8'h00; exp_adr[3] = 8'h01;
        do_reset();
        @(negedge clk); pc_load = 1; pc_in = 8'hFE;
        @(negedge clk); pc_load = 0; #1;
        total++; if (a_pc !== 8'hFE) $display("FAIL pl_load actual=%h required=FE", a_pc); else passed++;
        start = 1; mem_valid = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            #1;
            total++; if (a_adr !== exp_adr[b]) $display("FAIL pl_wrap%0d actual=%h required=%h", b, a_adr, exp_adr[b]); else passed++;
            @(negedge clk);
        end
        #1;
        total++; if (a_instr_valid !== 1'b1 || a_instr !== 32'h08202211 || a_pc !== 8'h02)
            $display("FAIL pl_done actual=%b/%h/%h required=1/08202211/02", a_instr_valid, a_instr, a_pc); else passed++;
        start = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin pc_load = 1; pc_in = 8'h40; end
            #1;
            total++; if (a_adr !== 8'(b + 2)) $display("FAIL pl_adr%0d actual=%h required=%h", b, a_adr, 8'(b + 2)); else passed++;
            @(negedge clk);
        end
        pc_load = 0; #1;
        total++; if (a_pc !== 8'h40 || a_instr_valid !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL pl_win actual=%h/%b/%b required=40/0/0", a_pc, a_instr_valid, a_busy); else passed++;
        @(negedge clk); #1;
        total++; if (a_instr_valid !== 1'b0) $display("FAIL pl_novalid actual=%b required=0", a_instr_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_valid = 1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int b = 0; b < 2; b++) begin
            #1;
            total++; if (b_adr !== 8'(b)) $display("FAIL be_adr%0d actual=%h required=%h", b, b_adr, 8'(b)); else passed++;
            @(negedge clk);
        end
        start = 1; #1;
        total++; if (b_instr_valid !== 1'b1 || b_instr !== 32'h00430820 || b_pc !== 8'h02)
            $display("FAIL be_first actual=%b/%h/%h required=1/00430820/02", b_instr_valid, b_instr, b_pc); else passed++;
        @(negedge clk); start = 0; #1;
        total++; if (b_instr_valid !== 1'b0 || b_adr !== 8'h02 || b_busy !== 1'b1)
            $display("FAIL b2b_c1 actual=%b/%h/%b required=0/02/1", b_instr_valid, b_adr, b_busy); else passed++;
        @(negedge clk); #1;
        total++; if (b_instr_valid !== 1'b0 || b_adr !== 8'h03)
            $display("FAIL b2b_c2 actual=%b/%h required=0/03", b_instr_valid, b_adr); else passed++;
        @(negedge clk); #1;
        total++; if (b_instr_valid !== 1'b1 || b_instr !== 32'h12345678 || b_pc !== 8'h04)
            $display("FAIL b2b_c3 actual=%b/%h/%h required=1/12345678/04", b_instr_valid, b_instr, b_pc); else passed++;
        start = 1;
        @(negedge clk); start = 0; #1;
        total++; if (b_adr !== 8'h04) $display("FAIL mr_adr actual=%h required=04", b_adr); else passed++;
        @(negedge clk); #1;
        total++; if (b_instr !== 32'hAAAA5678 || b_busy !== 1'b1)
            $display("FAIL mr_partial actual=%h/%b required=AAAA5678/1", b_instr, b_busy); else passed++;
        reset = 1;
        @(negedge clk); reset = 0; mem_valid = 0; #1;
        total++; if (b_instr !== 32'h0 || b_pc !== 8'h00 || b_busy !== 1'b0 || b_instr_valid !== 1'b0)
            $display("FAIL mr_reset actual=%h/%h/%b/%b required=0/00/0/0", b_instr, b_pc, b_busy, b_instr_valid); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mema[i] = 8'h00; memb[i] = 16'h0000; end
        mema[0] = 8'h20; mema[1] = 8'h08; mema[2] = 8'h43; mema[3] = 8'h00;
        mema[8'hFE] = 8'h11; mema[8'hFF] = 8'h22;
        memb[0] = 16'h0043; memb[1] = 16'h0820; memb[2] = 16'h1234; memb[3] = 16'h5678;
        memb[4] = 16'hAAAA; memb[5] = 16'hBBBB;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush();
        test_pc_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
